// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM state encoding, frame size and the
// scan codes that keyboard_display decodes.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      DATA   = 4'b0010,
      PARITY = 4'b0100,
      STOP   = 4'b1000
   } ps2_state_t;

   localparam int FRAME_BITS = 11;

   localparam logic [7:0] BREAK  = 8'hF0;
   localparam logic [7:0] LSHIFT = 8'h12;
   localparam logic [7:0] LCTRL  = 8'h14;

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings the raw PS/2 lines into the clk domain, de-glitches the clock line
// and emits a one-cycle fall pulse with the data bit sampled alongside it.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fall,
   output logic sample
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic                  clk_s1;
   logic                  clk_s2;
   logic                  dat_s1;
   logic                  dat_s2;
   logic                  filt_clk;
   logic [FW-1:0]         filt_cnt;
   logic [FILTER_LEN-1:0] dat_pipe;

   // The data pipe is as long as the filter delay so the sample lines up
   // with the filtered clock edge it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         dat_pipe <= '1;
         fall     <= 1'b0;
         sample   <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_dat;
         dat_s2 <= dat_s1;

         dat_pipe[0] <= dat_s2;
         for (int i = 1; i < FILTER_LEN; i++) begin
            dat_pipe[i] <= dat_pipe[i-1];
         end

         fall   <= 1'b0;
         sample <= dat_pipe[FILTER_LEN-1];

         if (clk_s2 != filt_clk) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
               filt_clk <= clk_s2;
               filt_cnt <= '0;
               fall     <= ~clk_s2;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: decodes 11-bit frames into bytes for
// keyboard_display and reports parity, framing and timeout errors.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] ps2dis_data,
   output logic       ps2dis_recFlag,
   output logic       parity_err,
   output logic       frame_err,
   output logic       timeout_err,
   output logic       busy,
   output logic [7:0] byte_cnt
);

   logic             fall;
   logic             sample;
   ps2_state_t       state;
   logic [7:0]       shift;
   logic [2:0]       bit_cnt;
   logic             parity_bit;
   logic [CNT_W-1:0] tcnt;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
      .clk     (clk),
      .rst     (rst),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .fall    (fall),
      .sample  (sample)
   );

   // A fall always wins over the timeout, so a bit arriving on the last
   // allowed cycle keeps the frame alive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         shift          <= '0;
         bit_cnt        <= '0;
         parity_bit     <= 1'b0;
         tcnt           <= '0;
         ps2dis_data    <= '0;
         ps2dis_recFlag <= 1'b0;
         parity_err     <= 1'b0;
         frame_err      <= 1'b0;
         timeout_err    <= 1'b0;
         busy           <= 1'b0;
         byte_cnt       <= '0;
      end else begin
         ps2dis_recFlag <= 1'b0;
         parity_err     <= 1'b0;
         frame_err      <= 1'b0;
         timeout_err    <= 1'b0;

         if (fall) begin
            tcnt <= '0;
            case (state)
               IDLE: begin
                  if (!sample) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                     busy    <= 1'b1;
                  end
               end
               DATA: begin
                  shift   <= {sample, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  parity_bit <= sample;
                  state      <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!sample) begin
                     frame_err <= 1'b1;
                  end else if (((^shift) ^ parity_bit) != 1'b1) begin
                     parity_err <= 1'b1;
                  end else begin
                     ps2dis_data    <= shift;
                     ps2dis_recFlag <= 1'b1;
                     byte_cnt       <= byte_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end else if (state != IDLE) begin
            if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state       <= IDLE;
               busy        <= 1'b0;
               timeout_err <= 1'b1;
               tcnt        <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed and random PS/2 frames
// compared against a frame-level reference model of the decoder.
module tb_ps2_receiver;

   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] ps2dis_data;
   logic       ps2dis_recFlag;
   logic       parity_err;
   logic       frame_err;
   logic       timeout_err;
   logic       busy;
   logic [7:0] byte_cnt;

   ps2_receiver #(
      .FILTER_LEN     (2),
      .TIMEOUT_CYCLES (200),
      .CNT_W          (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ps2_clk        (ps2_clk),
      .ps2_dat        (ps2_dat),
      .ps2dis_data    (ps2dis_data),
      .ps2dis_recFlag (ps2dis_recFlag),
      .parity_err     (parity_err),
      .frame_err      (frame_err),
      .timeout_err    (timeout_err),
      .busy           (busy),
      .byte_cnt       (byte_cnt)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   int cycle       = 0;
   int lastLow     = 0;

   int recCount   = 0;
   int parCount   = 0;
   int frmCount   = 0;
   int toCount    = 0;
   int toCycle    = 0;
   int busySeen   = 0;
   int multiCount = 0;
   logic [7:0] recLog[$];

   int         expRec     = 0;
   int         expPar     = 0;
   int         expFrm     = 0;
   int         expTo      = 0;
   logic [7:0] expData    = 8'h00;
   logic [7:0] expByteCnt = 8'h00;

   always @(posedge clk) cycle++;

   // Output monitor: counts every strobe and logs received bytes
   always @(negedge clk) begin
      if (ps2dis_recFlag) begin
         recCount++;
         recLog.push_back(ps2dis_data);
      end
      if (parity_err) parCount++;
      if (frame_err) frmCount++;
      if (timeout_err) begin
         toCount++;
         toCycle = cycle;
      end
      if (busy) busySeen++;
      if (int'(ps2dis_recFlag) + int'(parity_err) + int'(frame_err) + int'(timeout_err) > 1)
         multiCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic sendBit(input logic b);
      @(negedge clk);
      ps2_dat = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      lastLow = cycle;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Sends one complete frame and advances the reference model
   task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                                input bit busyCheck);
      sendBit(1'b0);
      if (busyCheck) checkOutput("busy_mid", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) sendBit(d[i]);
      sendBit(p);
      sendBit(s);
      ps2_dat = 1'b1;
      if (!s) begin
         expFrm++;
      end else if ((^d ^ p) != 1'b1) begin
         expPar++;
      end else begin
         expRec++;
         expData = d;
         expByteCnt = expByteCnt + 8'd1;
      end
   endtask

   task automatic checkState(input string tag);
      repeat (10) @(negedge clk);
      checkOutput({tag, "_rec"}, 32'(recCount), 32'(expRec));
      checkOutput({tag, "_par"}, 32'(parCount), 32'(expPar));
      checkOutput({tag, "_frm"}, 32'(frmCount), 32'(expFrm));
      checkOutput({tag, "_to"}, 32'(toCount), 32'(expTo));
      checkOutput({tag, "_data"}, 32'(ps2dis_data), 32'(expData));
      checkOutput({tag, "_bytecnt"}, 32'(byte_cnt), 32'(expByteCnt));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_data"}, 32'(ps2dis_data), 32'd0);
      checkOutput({tag, "_flags"},
                  32'({ps2dis_recFlag, parity_err, frame_err, timeout_err, busy}), 32'd0);
      checkOutput({tag, "_bytecnt"}, 32'(byte_cnt), 32'd0);
   endtask

   initial begin
      int n0;
      int b0;
      int dly;
      int mode;
      logic [7:0] d;
      logic p;
      logic s;

      repeat (5) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;
      repeat (10) @(negedge clk);

      $display("[TB] single valid frame");
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1);
      checkState("t1");

      $display("[TB] back-to-back frames");
      n0 = recLog.size();
      applyStimulus(8'hF0, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      checkState("t2");
      checkOutput("t2_count", 32'(recLog.size() - n0), 32'd2);
      checkOutput("t2_first", (recLog.size() > n0) ? 32'(recLog[n0]) : 32'hDEAD, 32'hF0);
      checkOutput("t2_second", (recLog.size() > n0 + 1) ? 32'(recLog[n0+1]) : 32'hDEAD, 32'h1C);

      $display("[TB] parity and framing errors");
      applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
      checkState("t3");
      applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
      checkState("t4");

      $display("[TB] timeout recovery");
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'b1);
      ps2_dat = 1'b1;
      repeat (300) @(negedge clk);
      expTo++;
      dly = toCycle - lastLow;
      checkOutput("t5_delay", 32'((dly >= 195) && (dly <= 215)), 32'd1);
      checkState("t5_abort");
      applyStimulus(8'h12, 1'b1, 1'b1, 1'b0);
      checkState("t5_next");

      $display("[TB] clock glitch in idle");
      b0 = busySeen;
      @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("t6_glitch_busy", 32'(busySeen - b0), 32'd0);
      checkState("t6_glitch");

      $display("[TB] reset mid-frame");
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkResetOutputs("t6_rst");
      expData = 8'h00;
      expByteCnt = 8'h00;
      ps2_dat = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      checkState("t6_after");

      $display("[TB] random frames");
      for (int k = 0; k < 20; k++) begin
         mode = int'($urandom_range(0, 5));
         d = 8'($urandom);
         p = ~^d;
         s = 1'b1;
         if (mode == 4) p = ^d;
         if (mode == 5) begin
            s = 1'b0;
            p = 1'($urandom);
         end
         applyStimulus(d, p, s, 1'b0);
         checkState("rand");
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end

      checkOutput("strobe_exclusive", 32'(multiCount), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
